mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15; maximum cycles a bus transaction may wait for mem_ready (valid range 1..255).
REQ-002 SHALL have parameter STARVE_MAX, default 2; maximum consecutive data grants issued while a fetch request is pending.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port fetch_req, input, 1, opcode-fetch request from the instruction sequencer; held high until fetch_done.
REQ-006 SHALL have port fetch_addr, input, 8, fetch address (program counter value).
REQ-007 SHALL have ports fetch_gnt (output, 1, one-cycle grant pulse), fetch_done (output, 1, one-cycle completion pulse) and fetch_data (output, 8, fetched opcode byte).
REQ-008 SHALL have ports data_req (input, 1), data_we (input, 1, 1 = write), data_addr (input, 8) and data_wdata (input, 8) for the operand/data requester.
REQ-009 SHALL have ports data_gnt (output, 1), data_done (output, 1) and data_rdata (output, 8).
REQ-010 SHALL have memory-side ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, 8), mem_wdata (output, 8), mem_rdata (input, 8) and mem_ready (input, 1).
REQ-011 SHALL have ports busy (output, 1, high in any non-IDLE state) and bus_err (output, 1, one-cycle timeout pulse).

Function
REQ-012 SHALL implement states IDLE, FETCH and DATA.
REQ-013 In IDLE with no request pending, SHALL stay in IDLE with mem_en=0.
REQ-014 Request sampled high in IDLE at edge N: SHALL enter FETCH or DATA at edge N and assert the matching gnt for exactly that one cycle.
REQ-015 At grant, SHALL register the address, we and wdata into mem_addr/mem_we/mem_wdata; these SHALL hold constant until the transaction ends. Fetch grants SHALL force mem_we=0.
REQ-016 SHALL hold mem_en=1 throughout FETCH/DATA and 0 in IDLE.
REQ-017 mem_ready sampled high in FETCH/DATA: SHALL latch mem_rdata into fetch_data/data_rdata (reads only), pulse the matching done for one cycle, and return to IDLE on the same edge.
REQ-018 Minimum turnaround: grant at cycle N, mem_ready at N -> done at N+1; next grant no earlier than N+2.
REQ-019 Arbitration when both requests are high in IDLE: data SHALL win unless starve_cnt equals STARVE_MAX, in which case fetch SHALL win.
REQ-020 starve_cnt SHALL increment on each data grant issued while fetch_req is high; SHALL clear on any fetch grant; SHALL saturate at STARVE_MAX.
REQ-021 Timeout counter SHALL clear on grant and increment each cycle in FETCH/DATA without mem_ready. Reaching TIMEOUT without mem_ready: SHALL pulse bus_err and the matching done, drive 8'hFF on the read-data output (write data is discarded), and return to IDLE.
REQ-022 mem_ready and timeout in the same cycle: mem_ready SHALL take precedence (normal completion, no bus_err).
REQ-023 Requester deasserting req mid-transaction SHALL NOT abort it; the transaction completes normally.
REQ-024 mem_ready in IDLE SHALL be ignored.
REQ-025 fetch_data and data_rdata SHALL hold their last value until the next completion of the same requester.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, clear starve_cnt and the timeout counter, and drive all outputs to 0 (including fetch_data, data_rdata, mem_addr and mem_wdata), independent of clk.
REQ-027 Reset mid-transaction SHALL discard the transaction with no done pulse; the first grant after release SHALL come no earlier than the first clk edge with rst_n high.

Verification
REQ-028 Fetch only: fetch_addr=8'h10, mem_ready one cycle after grant with mem_rdata=8'hA5 -> fetch_gnt one cycle, mem_addr=8'h10, mem_we=0, fetch_done pulse, fetch_data=8'hA5.
REQ-029 Data write: data_we=1, data_addr=8'h20, data_wdata=8'h3C, mem_ready at grant cycle -> mem_we=1, mem_wdata=8'h3C, data_done at N+1.
REQ-030 Fairness: fetch_req and data_req both held high -> grant order data, data, fetch, data, data, fetch.
REQ-031 Timeout: mem_ready held low with TIMEOUT=15 -> bus_err and data_done pulse 15 cycles after grant, data_rdata=8'hFF, busy low on the following cycle.
REQ-032 Reset mid-op: rst_n pulled low two cycles into FETCH -> mem_en=0 and busy=0 immediately, no fetch_done pulse; after release, a new fetch_req completes normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one 8-bit memory port between an opcode fetcher and a data requester,
// with anti-starvation for fetches and a per-transaction timeout.
module mem_bus_arbiter #(
    parameter int TIMEOUT    = 15,
    parameter int STARVE_MAX = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fetch_req,
    input  logic [7:0] fetch_addr,
    output logic       fetch_gnt,
    output logic       fetch_done,
    output logic [7:0] fetch_data,
    input  logic       data_req,
    input  logic       data_we,
    input  logic [7:0] data_addr,
    input  logic [7:0] data_wdata,
    output logic       data_gnt,
    output logic       data_done,
    output logic [7:0] data_rdata,
    output logic       mem_en,
    output logic       mem_we,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    output logic       busy,
    output logic       bus_err
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    state_t     state, state_nxt;
    logic [7:0] tmo_cnt;
    logic [7:0] starve_cnt;
    logic       gnt_f, gnt_d, fin, tmo;

    assign mem_en = (state != IDLE);
    assign busy   = (state != IDLE);

    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        gnt_f     = 1'b0;
        gnt_d     = 1'b0;
        fin       = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                // Data has priority until fetch has been passed over STARVE_MAX times.
                if (data_req && (!fetch_req || starve_cnt != STARVE_LIM)) begin
                    gnt_d     = 1'b1;
                    state_nxt = DATA;
                end else if (fetch_req) begin
                    gnt_f     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH, DATA: begin
                if (mem_ready) begin
                    fin       = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    fin       = 1'b1;
                    tmo       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_gnt  <= 1'b0;
            fetch_done <= 1'b0;
            fetch_data <= 8'h00;
            data_gnt   <= 1'b0;
            data_done  <= 1'b0;
            data_rdata <= 8'h00;
            mem_we     <= 1'b0;
            mem_addr   <= 8'h00;
            mem_wdata  <= 8'h00;
            bus_err    <= 1'b0;
            tmo_cnt    <= 8'h00;
            starve_cnt <= 8'h00;
        end else begin
            fetch_gnt  <= gnt_f;
            data_gnt   <= gnt_d;
            fetch_done <= fin && (state == FETCH);
            data_done  <= fin && (state == DATA);
            bus_err    <= tmo;

            if (gnt_f) begin
                mem_addr  <= fetch_addr;
                mem_we    <= 1'b0;
                mem_wdata <= 8'h00;
            end else if (gnt_d) begin
                mem_addr  <= data_addr;
                mem_we    <= data_we;
                mem_wdata <= data_wdata;
            end

            if (gnt_f || gnt_d)
                tmo_cnt <= 8'h00;
            else if (state != IDLE && !mem_ready)
                tmo_cnt <= tmo_cnt + 8'd1;

            if (gnt_f)
                starve_cnt <= 8'h00;
            else if (gnt_d && fetch_req && starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 8'd1;

            if (fin && state == FETCH)
                fetch_data <= tmo ? 8'hFF : mem_rdata;
            // Normal write completions leave the read-data register untouched.
            if (fin && state == DATA && (tmo || !mem_we))
                data_rdata <= tmo ? 8'hFF : mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch read, data write, fairness order,
// timeout and ready/timeout tie, mem_ready in IDLE, and reset mid-transaction.
module tb_mem_bus_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fetch_req, fetch_gnt, fetch_done;
    logic [7:0] fetch_addr, fetch_data;
    logic       data_req, data_we, data_gnt, data_done;
    logic [7:0] data_addr, data_wdata, data_rdata;
    logic       mem_en, mem_we, mem_ready, busy, bus_err;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    mem_bus_arbiter #(.TIMEOUT(15), .STARVE_MAX(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_gnt(fetch_gnt), .fetch_done(fetch_done), .fetch_data(fetch_data),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_done(data_done),
        .data_rdata(data_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [5:0] order_is_fetch = 6'b100100;  // index 0 = first grant
    int         early;

    initial begin
        rst_n = 1'b0;
        fetch_req = 0; fetch_addr = 0;
        data_req = 0; data_we = 0; data_addr = 0; data_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        #1;
        check("rst_mem_en", mem_en, 0);
        check("rst_busy", busy, 0);
        check("rst_outs", {fetch_gnt, fetch_done, data_gnt, data_done, mem_we, bus_err}, 0);
        check("rst_data", {fetch_data, data_rdata, mem_addr, mem_wdata}, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Idle with nothing pending
        tick();
        check("idle_mem_en", mem_en, 0);

        // Fetch read, ready one cycle after grant
        fetch_req = 1; fetch_addr = 8'h10;
        tick();
        check("f_gnt", fetch_gnt, 1);
        check("f_addr", mem_addr, 8'h10);
        check("f_we", mem_we, 0);
        check("f_busy", {mem_en, busy}, 2'b11);
        tick();
        check("f_gnt_pulse", {fetch_gnt, fetch_done}, 0);
        mem_ready = 1; mem_rdata = 8'hA5;
        tick();
        check("f_done", fetch_done, 1);
        check("f_data", fetch_data, 8'hA5);
        check("f_idle", mem_en, 0);
        fetch_req = 0; mem_ready = 0; mem_rdata = 8'h00;
        tick();
        check("f_done_pulse", fetch_done, 0);
        check("f_data_hold", fetch_data, 8'hA5);

        // Data write, ready in the grant cycle
        data_req = 1; data_we = 1; data_addr = 8'h20; data_wdata = 8'h3C;
        tick();
        check("w_gnt", data_gnt, 1);
        check("w_bus", {mem_we, mem_addr, mem_wdata}, {1'b1, 8'h20, 8'h3C});
        data_req = 0; mem_ready = 1; mem_rdata = 8'h99;
        tick();
        check("w_done", data_done, 1);
        check("w_busy", busy, 0);
        check("w_rdata_kept", data_rdata, 8'h00);
        mem_ready = 0;

        // mem_ready in IDLE is ignored
        mem_ready = 1;
        tick();
        check("idle_ready", {busy, data_done, fetch_done}, 0);
        mem_ready = 0;

        // Fairness with both requesters held
        fetch_req = 1; fetch_addr = 8'h11;
        data_req = 1; data_we = 0; data_addr = 8'h21;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("fair_gnt%0d", i), {fetch_gnt, data_gnt},
                  order_is_fetch[i] ? 2'b10 : 2'b01);
            mem_ready = 1; mem_rdata = 8'(i);
            tick();
            mem_ready = 0;
        end
        fetch_req = 0; data_req = 0;
        check("fair_fdata", fetch_data, 8'h05);
        check("fair_drdata", data_rdata, 8'h04);
        tick();

        // Timeout on a data read
        data_req = 1; data_we = 0; data_addr = 8'h30;
        tick();
        check("t_gnt", data_gnt, 1);
        data_req = 0;
        early = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus_err || data_done || !busy) early++;
        end
        check("t_no_early", early, 0);
        tick();
        check("t_err", {bus_err, data_done}, 2'b11);
        check("t_rdata", data_rdata, 8'hFF);
        check("t_busy", busy, 0);
        tick();
        check("t_after", {bus_err, data_done, busy}, 0);

        // mem_ready exactly on the timeout cycle wins
        data_req = 1; data_addr = 8'h31;
        tick();
        data_req = 0;
        repeat (14) tick();
        mem_ready = 1; mem_rdata = 8'h5A;
        tick();
        check("tie_done", {bus_err, data_done}, 2'b01);
        check("tie_rdata", data_rdata, 8'h5A);
        mem_ready = 0;
        tick();

        // Reset two cycles into FETCH
        fetch_req = 1; fetch_addr = 8'h40;
        tick();
        check("r_gnt", fetch_gnt, 1);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("r_async", {mem_en, busy}, 0);
        check("r_regs", {mem_addr, fetch_data, data_rdata}, 0);
        @(posedge clk);
        #1;
        check("r_no_done", {fetch_done, fetch_gnt}, 0);
        #3 rst_n = 1'b1;
        #1;
        check("r_rel_idle", {busy, fetch_gnt}, 0);
        tick();
        check("r2_gnt", fetch_gnt, 1);
        check("r2_addr", mem_addr, 8'h40);
        fetch_req = 0; mem_ready = 1; mem_rdata = 8'h77;
        tick();
        check("r2_done", fetch_done, 1);
        check("r2_data", fetch_data, 8'h77);
        mem_ready = 0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
